// File: rtl/alu_result_stage_if.sv
// ALU-to-writeback handshake bundle for alu_result_stage.
// Upstream ALU side (in_*), writeback side (out_*), flush, and flags.
interface alu_result_stage_if #(
  parameter int WIDTH = 24,
  parameter int RD_W  = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_cout;
  logic             in_cin_msb;
  logic [2:0]       in_op;
  logic [RD_W-1:0]  in_rd;
  logic             in_wb_en;
  logic             in_setflags;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [RD_W-1:0]  out_rd;
  logic             out_wb_en;
  logic [3:0]       flags_nzcv;

  modport slave (
    input  in_valid, in_result, in_cout,
    input  in_cin_msb, in_op, in_rd,
    input  in_wb_en, in_setflags, flush,
    input  out_ready,
    output in_ready, out_valid, out_result,
    output out_rd, out_wb_en, flags_nzcv
  );

  modport master (
    output in_valid, in_result, in_cout,
    output in_cin_msb, in_op, in_rd,
    output in_wb_en, in_setflags, flush,
    output out_ready,
    input  in_ready, out_valid, out_result,
    input  out_rd, out_wb_en, flags_nzcv
  );
endinterface

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: 2-entry skid buffer with NZCV flags
// committed to the architectural register only when an entry retires.
module alu_result_stage #(
  parameter int WIDTH = 24,
  parameter int RD_W  = 4
) (
  input logic clk,
  input logic rst_n,
  alu_result_stage_if.slave io
);
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [RD_W-1:0]  rd;
    logic             wb_en;
    logic             setflags;
    logic [3:0]       nzcv;
    logic             keep;
  } ent_t;

  ent_t       main_q, main_d;
  ent_t       skid_q, skid_d;
  ent_t       in_ent;
  logic       main_v_q, main_v_d;
  logic       skid_v_q, skid_v_d;
  logic [3:0] flags_q, flags_d;
  logic       arith;
  logic       accept;
  logic       retire;

  always_comb begin
    arith = 1'b0;
    unique case (io.in_op)
      3'b010, 3'b011: arith = 1'b1;
      default:        arith = 1'b0;
    endcase
    in_ent.result   = io.in_result;
    in_ent.rd       = io.in_rd;
    in_ent.wb_en    = io.in_wb_en;
    in_ent.setflags = io.in_setflags;
    in_ent.keep     = !arith;
    in_ent.nzcv[3]  = io.in_result[WIDTH-1];
    in_ent.nzcv[2]  = (io.in_result == '0);
    in_ent.nzcv[1]  = arith & io.in_cout;
    in_ent.nzcv[0]  = arith & (io.in_cout ^ io.in_cin_msb);
  end

  // in_ready comes straight from the skid flop: no out_ready path
  assign accept = io.in_valid && !skid_v_q && !io.flush;
  assign retire = main_v_q && io.out_ready;

  always_comb begin
    main_v_d = main_v_q;
    main_d   = main_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    flags_d  = flags_q;
    if (retire) begin
      main_v_d = skid_v_q;
      skid_v_d = 1'b0;
      if (skid_v_q) main_d = skid_q;
      if (main_q.setflags) begin
        flags_d[3:2] = main_q.nzcv[3:2];
        if (!main_q.keep) flags_d[1:0] = main_q.nzcv[1:0];
      end
    end
    if (accept) begin
      if (!main_v_q || retire) begin
        main_d   = in_ent;
        main_v_d = 1'b1;
      end else begin
        skid_d   = in_ent;
        skid_v_d = 1'b1;
      end
    end
    if (io.flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
      flags_q  <= 4'b0000;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      flags_q  <= flags_d;
    end
  end

  assign io.in_ready   = !skid_v_q;
  assign io.out_valid  = main_v_q;
  assign io.out_result = main_q.result;
  assign io.out_rd     = main_q.rd;
  assign io.out_wb_en  = main_q.wb_en;
  assign io.flags_nzcv = flags_q;
endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Execute-to-writeback buffering stage directly downstream of the 24-bit ALU built from 1-bit ALU slices. It captures the ALU result with its destination tag and computes N/Z/C/V flags from the MSB slice's carries. A two-entry skid buffer decouples the ALU from writeback backpressure. Flags commit to an architectural flag register only when an entry retires.

## Interface
- WIDTH, 24, datapath width (ALU slice count)
- RD_W, 4, destination register index width

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ALU output valid
- in_ready  out  1  stage can accept
- in_result  in  WIDTH  ALU Result bus
- in_cout  in  1  CarryOut of slice WIDTH-1
- in_cin_msb  in  1  CarryIn of slice WIDTH-1
- in_op  in  3  Operation code driven to the ALU
- in_rd  in  RD_W  destination register
- in_wb_en  in  1  register write enable
- in_setflags  in  1  commit flags on retire
- flush  in  1  discard buffered and incoming entries
- out_valid  out  1  entry available to writeback
- out_ready  in  1  writeback accepts
- out_result  out  WIDTH  buffered result
- out_rd  out  RD_W  buffered destination
- out_wb_en  out  1  buffered write enable
- flags_nzcv  out  4  architectural flags {N,Z,C,V}

## Operation
- Operation codes: 000 AND, 001 OR, 010 ADD/SUB, 011 SLT, 100 XOR; 101–111 treated as logic ops.
- Per-entry flags computed at accept: N = in_result[WIDTH-1]; Z = (in_result == 0); for 010/011, C = in_cout and V = in_cout ^ in_cin_msb; for all other codes C and V carry the "keep" marker (retain the architectural value on commit).
- Storage: main register (drives out_*) and skid register, each with a valid bit, result, rd, wb_en, setflags, flags, and keep marker.
- Accept: in_valid && in_ready && !flush.
- Retire: out_valid && out_ready.
- Accepted entry goes to main if main is empty or retiring in the same cycle and the skid is empty. Otherwise it goes to skid.
- On retire with skid valid, skid moves to main and skid clears.
- in_ready = !skid_valid, derived from a register only, with no combinational path from out_ready.
- Commit: on retire with setflags = 1, flags_nzcv takes N, Z, and C/V (or the retained C/V when keep). With setflags = 0 or no retire, flags are unchanged.
- Flush: a retire in the flush cycle still completes and commits its flags. Every other buffered entry is invalidated and the input is not accepted. in_ready is 1 in the next cycle.
- Ordering is strictly FIFO, and no entry is ever duplicated or dropped except by flush.

## Timing
- Reset (async assert, sync release): out_valid 0, skid valid 0, in_ready 1, out_result 0, out_rd 0, out_wb_en 0, flags_nzcv 0000.
- Latency is 1 cycle: an entry accepted at edge k is visible on out_* after edge k.
- Throughput is 1 entry/cycle while out_ready is held at 1.
- With out_ready low, the stage holds 2 entries and in_ready drops after the second accept. out_* stays stable while out_valid && !out_ready.
- Simultaneous accept and retire with skid empty: main reloads from the input, skid stays empty.
- Simultaneous accept and retire with skid full is impossible, because in_ready = 0.
- Reset asserted mid-operation clears all entries immediately; flags return to 0000.

## Test plan
- ADD commit: in_op=010, in_result=0x000000, in_cout=1, in_cin_msb=1, setflags=1, out_ready=1 -> out_result=0x000000 next cycle; flags_nzcv=0110 one edge after retire.
- Signed overflow: in_op=010, in_result=0x800000, in_cout=0, in_cin_msb=1, setflags=1 -> flags_nzcv=1001.
- Logic keeps C/V: from flags 0011, XOR with in_result=0x000001 and setflags=1 -> flags_nzcv=0011; the same entry with setflags=0 leaves the flags unchanged.
- Backpressure: out_ready=0, feed A=0x111111 then B=0x222222 -> in_ready=0 after B; C=0x333333 held off; out_ready=1 -> output sequence A, B, C, one per cycle, no gaps after the first.
- Flush: two entries buffered, assert flush with out_ready=1 -> head entry retires and commits; the second entry and the concurrent input are dropped; out_valid=0 and in_ready=1 next cycle.
- Async reset with two entries buffered and flags 1111 -> out_valid=0, in_ready=1, flags_nzcv=0000 without waiting for a clock edge.
